// File: rtl/mem_wb_stage_pkg.sv
// Shared op/func codes and writeback source-select constants for the MIPS core.
// Imported by the MEM/WB stage and the load extender.
package mem_wb_stage_pkg;

  // Primary opcodes
  localparam logic [5:0] CALCU = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] ADDIU = 6'h09;
  localparam logic [5:0] SLTI  = 6'h0a;
  localparam logic [5:0] SLTIU = 6'h0b;
  localparam logic [5:0] ANDI  = 6'h0c;
  localparam logic [5:0] ORI   = 6'h0d;
  localparam logic [5:0] XORI  = 6'h0e;
  localparam logic [5:0] LUI   = 6'h0f;
  localparam logic [5:0] LB    = 6'h20;
  localparam logic [5:0] LH    = 6'h21;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] LBU   = 6'h24;
  localparam logic [5:0] LHU   = 6'h25;
  localparam logic [5:0] SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] SLL_FUNC  = 6'h00;
  localparam logic [5:0] SRL_FUNC  = 6'h02;
  localparam logic [5:0] SRA_FUNC  = 6'h03;
  localparam logic [5:0] SLLV_FUNC = 6'h04;
  localparam logic [5:0] SRLV_FUNC = 6'h06;
  localparam logic [5:0] SRAV_FUNC = 6'h07;
  localparam logic [5:0] JR_FUNC   = 6'h08;
  localparam logic [5:0] JALR_FUNC = 6'h09;
  localparam logic [5:0] MFHI_FUNC = 6'h10;
  localparam logic [5:0] MTHI_FUNC = 6'h11;
  localparam logic [5:0] MFLO_FUNC = 6'h12;
  localparam logic [5:0] MTLO_FUNC = 6'h13;
  localparam logic [5:0] MULT_FUNC = 6'h18;
  localparam logic [5:0] ADD_FUNC  = 6'h20;
  localparam logic [5:0] ADDU_FUNC = 6'h21;
  localparam logic [5:0] SUB_FUNC  = 6'h22;
  localparam logic [5:0] SUBU_FUNC = 6'h23;
  localparam logic [5:0] AND_FUNC  = 6'h24;
  localparam logic [5:0] OR_FUNC   = 6'h25;
  localparam logic [5:0] XOR_FUNC  = 6'h26;
  localparam logic [5:0] NOR_FUNC  = 6'h27;
  localparam logic [5:0] SLT_FUNC  = 6'h2a;
  localparam logic [5:0] SLTU_FUNC = 6'h2b;

  // Writeback data source select
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

endpackage

// File: rtl/mem_wb_stage_load_extender.sv
// Little-endian byte/halfword select and sign/zero extension of a loaded word.
// Purely combinational so it can be shared with a future cache return path.
module load_extender
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [5:0]  op,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*off +: 8];
    // Misaligned halfwords are trapped upstream, so only off[1] matters here.
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      LB:      ext = {{24{byte_sel[7]}}, byte_sel};
      LBU:     ext = {24'h0, byte_sel};
      LH:      ext = {{16{half_sel[15]}}, half_sel};
      LHU:     ext = {16'h0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback datapath: drives the register-file write
// port (also seen by the hazard/forwarding unit) from the registered instruction.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [4:0]  RA_ADDR   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] mem_instr,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata,
  input  logic        mem_overflow,
  output logic [31:0] wb_instr,
  output logic [31:0] wb_pc,
  output logic        wb_reg_we,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_wdata,
  output logic        wb_valid
);

  logic [31:0] instr_q, pc_q, alu_q, rdata_q;
  logic        ovf_q, valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= mem_instr;
      pc_q    <= mem_pc;
      alu_q   <= mem_alu_result;
      rdata_q <= mem_rdata;
      ovf_q   <= mem_overflow;
      valid_q <= 1'b1;
    end
  end

  logic [5:0]  op, func;
  logic        writes;
  logic [1:0]  wb_sel;
  logic [4:0]  addr;
  logic [31:0] load_data;

  assign op   = instr_q[31:26];
  assign func = instr_q[5:0];

  always_comb begin
    writes = 1'b0;
    wb_sel = WB_SEL_ALU;
    addr   = instr_q[20:16];
    case (op)
      CALCU: begin
        addr = instr_q[15:11];
        case (func)
          ADD_FUNC, SUB_FUNC: writes = !ovf_q;
          ADDU_FUNC, SUBU_FUNC, AND_FUNC, OR_FUNC, XOR_FUNC, NOR_FUNC, SLT_FUNC, SLTU_FUNC,
          SLL_FUNC, SRL_FUNC, SRA_FUNC, SLLV_FUNC, SRLV_FUNC, SRAV_FUNC,
          MFHI_FUNC, MFLO_FUNC: writes = 1'b1;
          JALR_FUNC: begin
            writes = 1'b1;
            wb_sel = WB_SEL_PC;
          end
          default: writes = 1'b0;
        endcase
      end
      JAL: begin
        writes = 1'b1;
        addr   = RA_ADDR;
        wb_sel = WB_SEL_PC;
      end
      ADDI: writes = !ovf_q;
      ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: writes = 1'b1;
      LB, LBU, LH, LHU, LW: begin
        writes = 1'b1;
        wb_sel = WB_SEL_MEM;
      end
      default: writes = 1'b0;
    endcase
  end

  load_extender u_load_extender (
    .rdata (rdata_q),
    .off   (alu_q[1:0]),
    .op    (op),
    .ext   (load_data)
  );

  always_comb begin
    case (wb_sel)
      WB_SEL_PC:  wb_reg_wdata = pc_q + 32'd8;
      WB_SEL_MEM: wb_reg_wdata = load_data;
      default:    wb_reg_wdata = alu_q;
    endcase
  end

  // $0 is hardwired; suppressing its write keeps forwarding from seeing a bogus producer.
  assign wb_reg_we   = valid_q & writes & (addr != 5'd0);
  assign wb_reg_addr = addr;
  assign wb_instr    = instr_q;
  assign wb_pc       = pc_q;
  assign wb_valid    = valid_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed checks of mem_wb_stage against a behavioural writeback model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, mem_overflow;
  logic [31:0] mem_instr, mem_pc, mem_alu_result, mem_rdata;
  logic [31:0] wb_instr, wb_pc, wb_reg_wdata;
  logic        wb_reg_we, wb_valid;
  logic [4:0]  wb_reg_addr;

  int checks = 0;
  int errors = 0;

  // Model of the registered MEM/WB contents
  logic [31:0] m_instr, m_pc, m_alu, m_rdata;
  logic        m_ovf, m_valid;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_instr      (mem_instr),
    .mem_pc         (mem_pc),
    .mem_alu_result (mem_alu_result),
    .mem_rdata      (mem_rdata),
    .mem_overflow   (mem_overflow),
    .wb_instr       (wb_instr),
    .wb_pc          (wb_pc),
    .wb_reg_we      (wb_reg_we),
    .wb_reg_addr    (wb_reg_addr),
    .wb_reg_wdata   (wb_reg_wdata),
    .wb_valid       (wb_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic ref_writes(input logic [31:0] ins, input logic ovf);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h22) return !ovf;
      return fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                        6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12};
    end
    if (op == 6'h08) return !ovf;
    return op inside {6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h03};
  endfunction

  function automatic logic [4:0] ref_addr(input logic [31:0] ins);
    if (ins[31:26] == 6'h03) return 5'd31;
    if (ins[31:26] == 6'h00) return ins[15:11];
    return ins[20:16];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] ins, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * alu[1:0]));
    h = 16'(rd >> (16 * alu[1]));
    if (ins[31:26] == 6'h03 || (ins[31:26] == 6'h00 && ins[5:0] == 6'h09)) return pc + 32'd8;
    case (ins[31:26])
      6'h20:   return 32'($signed(b));
      6'h24:   return {24'h0, b};
      6'h21:   return 32'($signed(h));
      6'h25:   return {16'h0, h};
      6'h23:   return rd;
      default: return alu;
    endcase
  endfunction

  task automatic model_clear();
    m_instr = '0; m_pc = '0; m_alu = '0; m_rdata = '0; m_ovf = 1'b0; m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] ea;
    ea = ref_addr(m_instr);
    check_eq({tag, ".instr"}, wb_instr, m_instr);
    check_eq({tag, ".pc"}, wb_pc, m_pc);
    check_eq({tag, ".valid"}, 32'(wb_valid), 32'(m_valid));
    check_eq({tag, ".addr"}, 32'(wb_reg_addr), 32'(ea));
    check_eq({tag, ".we"}, 32'(wb_reg_we),
             32'(m_valid && ref_writes(m_instr, m_ovf) && ea != 5'd0));
    check_eq({tag, ".wdata"}, wb_reg_wdata, ref_wdata(m_instr, m_pc, m_alu, m_rdata));
  endtask

  task automatic step(input string tag, input logic st, input logic fl, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rd,
                      input logic ovf);
    stall = st; flush = fl; mem_instr = ins; mem_pc = pc;
    mem_alu_result = alu; mem_rdata = rd; mem_overflow = ovf;
    @(posedge clk);
    if (fl) model_clear();
    else if (!st) begin
      m_instr = ins; m_pc = pc; m_alu = alu; m_rdata = rd; m_ovf = ovf; m_valid = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  logic [5:0] op_pool [0:17] = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h08, 6'h09, 6'h0a, 6'h0d, 6'h0f,
                                 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2b, 6'h04, 6'h02, 6'h0e};
  logic [5:0] fn_pool [0:11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h25, 6'h09, 6'h08, 6'h00,
                                 6'h10, 6'h18, 6'h2a, 6'h07};

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; mem_overflow = 1'b0;
    mem_instr = '0; mem_pc = '0; mem_alu_result = '0; mem_rdata = '0;
    model_clear();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-stream with a valid LW in WB
    step("lw_pre", 0, 0, itype(6'h23, 5'd1, 5'd3, 16'h0), 32'h100, 32'h2000, 32'hCAFE0001, 0);
    check_eq("lw_pre.we_lit", 32'(wb_reg_we), 32'd1);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check_all("reset_mid");
    @(posedge clk); #1;
    check_all("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("reset_rel.we", 32'(wb_reg_we), 32'd0);

    // Loads: alu_result 0x1003 / 0x1002, rdata 0x80112233
    step("lb", 0, 0, itype(6'h20, 5'd2, 5'd9, 16'h3), 32'h10, 32'h1003, 32'h80112233, 0);
    check_eq("lb.lit", wb_reg_wdata, 32'hFFFFFF80);
    step("lbu", 0, 0, itype(6'h24, 5'd2, 5'd9, 16'h3), 32'h14, 32'h1003, 32'h80112233, 0);
    check_eq("lbu.lit", wb_reg_wdata, 32'h00000080);
    step("lh", 0, 0, itype(6'h21, 5'd2, 5'd9, 16'h2), 32'h18, 32'h1002, 32'h80112233, 0);
    check_eq("lh.lit", wb_reg_wdata, 32'hFFFF8011);
    step("lhu", 0, 0, itype(6'h25, 5'd2, 5'd9, 16'h2), 32'h1c, 32'h1002, 32'h80112233, 0);
    check_eq("lhu.lit", wb_reg_wdata, 32'h00008011);
    step("lw", 0, 0, itype(6'h23, 5'd2, 5'd9, 16'h0), 32'h20, 32'h1000, 32'h80112233, 0);
    check_eq("lw.lit", wb_reg_wdata, 32'h80112233);

    // Links
    step("jal", 0, 0, {6'h03, 26'h0000C00}, 32'h00003000, 32'h0, 32'h0, 0);
    check_eq("jal.lit", wb_reg_wdata, 32'h00003008);
    check_eq("jal.addr_lit", 32'(wb_reg_addr), 32'd31);
    step("jalr", 0, 0, rtype(5'd4, 5'd0, 5'd5, 6'h09), 32'hFFFFFFFC, 32'h0, 32'h0, 0);
    check_eq("jalr.lit", wb_reg_wdata, 32'h00000004);

    // Overflow gating and $0 suppression
    step("add_ovf", 0, 0, rtype(5'd1, 5'd2, 5'd8, 6'h20), 32'h30, 32'h7, 32'h0, 1);
    check_eq("add_ovf.lit", 32'(wb_reg_we), 32'd0);
    step("addu_ovf", 0, 0, rtype(5'd1, 5'd2, 5'd8, 6'h21), 32'h34, 32'h7, 32'h0, 1);
    check_eq("addu_ovf.lit", 32'(wb_reg_we), 32'd1);
    step("addi_r0", 0, 0, itype(6'h08, 5'd1, 5'd0, 16'h5), 32'h38, 32'h5, 32'h0, 0);
    check_eq("addi_r0.lit", 32'(wb_reg_we), 32'd0);

    // Stall holds, flush beats stall
    step("ori", 0, 0, itype(6'h0d, 5'd1, 5'd4, 16'h55), 32'h40, 32'h55, 32'h0, 0);
    step("stall1", 1, 0, itype(6'h23, 5'd3, 5'd6, 16'h0), 32'h44, 32'h99, 32'h1234, 0);
    step("stall2", 1, 0, rtype(5'd3, 5'd6, 5'd7, 6'h21), 32'h48, 32'hAA, 32'h0, 1);
    check_eq("stall2.we_lit", 32'(wb_reg_we), 32'd1);
    step("flush_stall", 1, 1, itype(6'h0d, 5'd1, 5'd4, 16'h55), 32'h4c, 32'h55, 32'h0, 0);
    check_eq("flush_stall.instr_lit", wb_instr, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [5:0]  op;
      op  = op_pool[$urandom_range(17)];
      ins = $urandom;
      ins[31:26] = op;
      if (op == 6'h00) ins[5:0] = fn_pool[$urandom_range(11)];
      step("rand", ($urandom_range(5) == 0), ($urandom_range(9) == 0), ins, $urandom, $urandom,
           $urandom, ($urandom_range(3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register plus writeback datapath for the 5-stage MIPS core. Captures MEM-stage instruction, PC, ALU result, data-memory read word and overflow flag each cycle. Drives the register-file write port (enable, address, data) from the registered instruction. The same write port is exported to the hazard/forwarding unit. Write-enable and source-select decode uses the shared op/func constants.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word loaded on reset/flush (sll $0,$0,0)
RA_ADDR, 5'd31, link register number for JAL

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset)
stall  input  1  hold all WB registers this cycle
flush  input  1  load bubble (NOP) this cycle
mem_instr  input  32  instruction in MEM
mem_pc  input  32  PC of instruction in MEM
mem_alu_result  input  32  ALU/HI/LO result, also data-memory byte address
mem_rdata  input  32  aligned word read from data memory at mem_alu_result[31:2]
mem_overflow  input  1  signed overflow from EX for ADD/SUB/ADDI
wb_instr  output  32  registered instruction (for Tnew/hazard decode)
wb_pc  output  32  registered PC
wb_reg_we  output  1  register-file write enable
wb_reg_addr  output  5  register-file write address
wb_reg_wdata  output  32  register-file write data
wb_valid  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Registers: instr, pc, alu_result, rdata, overflow, valid; all other outputs combinational from these.
- Reset (reset=0, async): instr=NOP_INSTR, pc=0, alu_result=0, rdata=0, overflow=0, valid=0, so wb_reg_we=0, wb_reg_addr=0, wb_reg_wdata=0. Reset mid-stream discards the in-flight instruction; no write occurs in the reset cycle or the first cycle after release.
- Edge priority: reset > flush > stall > load. flush=1 loads NOP/zeros and valid=0, regardless of stall. stall=1 (no flush) holds all registers. Otherwise load mem_* and valid=1.
- Latency: one cycle MEM to WB; write data is valid in the same cycle as wb_instr.
- Write address: JAL gives RA_ADDR; op==CALCU (R-type, incl. JALR) gives instr[15:11]; all other writing ops give instr[20:16].
- Write enable: same instruction set as the existing MEM/WB decode. ADD/SUB/ADDI are gated by registered overflow==0; ADDU/SUBU never gated. Forced 0 when wb_valid=0 or wb_reg_addr==0.
- Data select: JAL/JALR gives pc+8 (32-bit wrap, 0xFFFFFFFC+8 = 0x00000004). Loads give the extended value. Otherwise alu_result.
- Load extension, little-endian, off=alu_result[1:0]:
  - LB/LBU select byte off (off 0 = bits 7:0), then sign-/zero-extend.
  - LH/LHU select halfword off[1] (0 = bits 15:0), then extend; off[0] ignored, since alignment exceptions are handled upstream.
  - LW passes rdata unchanged.
- Stall holds wb_reg_we asserted. The register file must tolerate repeated identical writes.

Decomposition:
- Op/func codes (LB, LBU, LH, LHU, LW, JAL, CALCU, JALR_FUNC, ADD_FUNC, ...) stay in the shared defines.v.
- Add WB_SEL_ALU/WB_SEL_MEM/WB_SEL_PC select constants there.
- One sub-module: load_extender. Inputs: rdata[31:0], off[1:0], instr op. Output: 32-bit extended word. Purely combinational and reused by a future cache path.

Test Plan:
- Reset asserted mid-stream while LW valid, then released -> all outputs 0 immediately, wb_reg_we=0 until next loaded instruction.
- LB, alu_result=0x1003, rdata=0x80112233 -> wdata=0xFFFFFF80, addr=rt. LBU same -> 0x00000080. LH off=2 -> 0xFFFF8011. LHU -> 0x00008011. LW -> 0x80112233.
- JAL, pc=0x00003000 -> addr=31, wdata=0x00003008, we=1. JALR rd=5, pc=0xFFFFFFFC -> addr=5, wdata=0x00000004.
- ADD rd=8, overflow=1 -> we=0. ADDU rd=8, overflow=1, alu=0x7 -> we=1, wdata=0x7. ADDI rt=0, overflow=0 -> we=0 (addr 0).
- ORI loaded, then stall=1 for 2 cycles -> outputs held identical. flush=1 with stall=1 -> next edge wb_valid=0, we=0, wb_instr=0.
